// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit feeder: default sizes and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_FRAME_WD_DEF = 8;
    localparam int UART_DEPTH_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter-facing bundle of the feeder; drop_cnt exists only with UART_TX_FEEDER_DROP_CNT_EN.
// Latency: n/a (wires only).
// Backpressure: producer observes full/level; pushes while full are dropped by the feeder.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int FRAME_WD = UART_FRAME_WD_DEF,
    parameter int DEPTH    = UART_DEPTH_DEF
);

    localparam int LVL_WD = $clog2(DEPTH) + 1;

    logic                wr_en;
    logic [FRAME_WD-1:0] wr_data;
    logic                full;
    logic                empty;
    logic [LVL_WD-1:0]   level;
    logic                frame_en;
    logic [FRAME_WD-1:0] data_frame;
    logic                tx_done;
    logic                busy;
    logic                overflow;
    logic                timeout_err;
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    logic [15:0]         drop_cnt;
`endif

    // Feeder side
    modport slave (
        input  wr_en,
        input  wr_data,
        input  tx_done,
        output full,
        output empty,
        output level,
        output frame_en,
        output data_frame,
        output busy,
        output overflow,
        output timeout_err
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        , output drop_cnt
`endif
    );

    // Producer + transmitter side
    modport master (
        output wr_en,
        output wr_data,
        output tx_done,
        input  full,
        input  empty,
        input  level,
        input  frame_en,
        input  data_frame,
        input  busy,
        input  overflow,
        input  timeout_err
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        , input drop_cnt
`endif
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Circular-buffer FIFO with wrapping pointers and an occupancy counter.
// Latency: push visible on the next cycle; head is read combinationally.
// Backpressure: push ignored while full, pop ignored while empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues producer bytes and launches them one frame at a time into a UART frame transmitter (UART_TX_FEEDER_DROP_CNT_EN adds drop_cnt).
// Latency: push to frame_en is 2 cycles when idle; next frame_en 3 cycles after tx_done.
// Backpressure: none to the producer beyond full; pushes while full are dropped and flagged.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int FRAME_WD    = UART_FRAME_WD_DEF,
    parameter int DEPTH       = UART_DEPTH_DEF,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic               clk,
    input  logic               reset_p,
    uart_tx_feeder_if.slave    bus
);

    localparam int LVL_WD = $clog2(DEPTH) + 1;
    localparam int CNT_WD = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(TIMEOUT_CYC - 1);

    tx_state_e           state_q, state_d;
    logic [FRAME_WD-1:0] data_q, data_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                tout_q, tout_d;
    logic                frame_en;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_WD-1:0]   fifo_level;
    logic [FRAME_WD-1:0] fifo_head;

    uart_sync_fifo #(
        .WIDTH (FRAME_WD),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_p (reset_p),
        .push_i  (bus.wr_en),
        .pop_i   (pop),
        .din_i   (bus.wr_data),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Full is judged before this cycle's pop, so a push racing a pop is still dropped
    assign drop = bus.wr_en & fifo_full;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = '0;
        ovf_d    = ovf_q | drop;
        tout_d   = tout_q;
        pop      = 1'b0;
        frame_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Payload is captured on entry so it is already valid during the frame_en cycle
                if (!fifo_empty) begin
                    state_d = ST_LAUNCH;
                    data_d  = fifo_head;
                end
            end
            ST_LAUNCH: begin
                frame_en = 1'b1;
                pop      = 1'b1;
                state_d  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    state_d = ST_GAP;
                end else if (cnt_q == CNT_LAST) begin
                    tout_d  = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.full        = fifo_full;
    assign bus.empty       = fifo_empty;
    assign bus.level       = fifo_level;
    assign bus.frame_en    = frame_en;
    assign bus.data_frame  = data_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.overflow    = ovf_q;
    assign bus.timeout_err = tout_q;

`ifdef UART_TX_FEEDER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule
